// File: rtl/norm_frame_writer.sv
// Buffers one cropped frame, publishes its maximum as norm_denominator, then replays it in order.
// Optional `define NORM_FRAME_WRITER_TLAST_CHECK_EN adds s_axis_tlast/frame_err and early frame termination.
module norm_frame_writer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_ready,
    output logic                       ap_idle,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
    input  logic                       s_axis_tlast,
`endif
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [PIXEL_BIT_WIDTH-1:0] norm_denominator,
    output logic                       norm_valid
`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
    ,
    output logic                       frame_err
`endif
);

    localparam int N  = OUT_ROWS * OUT_COLS;
    localparam int CW = $clog2(N + 1);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t state, next_state;

    logic [PIXEL_BIT_WIDTH-1:0] mem [N];
    logic [CW-1:0]              wr_cnt;
    logic [CW-1:0]              rd_cnt;
    logic [CW-1:0]              rd_next;
    logic [CW-1:0]              last_idx;
    logic [PIXEL_BIT_WIDTH-1:0] max_q;
    logic [PIXEL_BIT_WIDTH-1:0] cur_max;
    logic [PIXEL_BIT_WIDTH-1:0] m_data;
    logic                       m_valid;
    logic                       in_hs;
    logic                       frame_end;
    logic                       out_last;

    assign in_hs    = s_axis_tready && s_axis_tvalid;
    assign cur_max  = (s_axis_tdata > max_q) ? s_axis_tdata : max_q;
    assign rd_next  = rd_cnt + CW'(1);
    assign out_last = (rd_cnt == last_idx);

`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
    assign frame_end = in_hs && ((wr_cnt == LAST) || s_axis_tlast);
`else
    assign frame_end = in_hs && (wr_cnt == LAST);
    assign last_idx  = LAST;
`endif

    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = m_data;
    assign m_axis_tlast  = m_valid && out_last;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ap_start) next_state = CAPTURE;
            CAPTURE: if (frame_end) next_state = DRAIN;
            DRAIN:   if (m_valid && m_axis_tready && out_last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ap_idle       = (state == IDLE);
        ap_ready      = (state == IDLE);
        ap_done       = (state == DONE);
        s_axis_tready = (state == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (in_hs) mem[wr_cnt[AW-1:0]] <= s_axis_tdata;
    end

    // The output register is the buffer's read register; its address advances only on an
    // output handshake, so data holds under backpressure yet one pixel per cycle is sustained.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            max_q            <= '0;
            m_valid          <= 1'b0;
            m_data           <= '0;
            norm_valid       <= 1'b0;
            norm_denominator <= PIXEL_BIT_WIDTH'(1);
`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
            last_idx         <= LAST;
            frame_err        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        wr_cnt     <= '0;
                        rd_cnt     <= '0;
                        max_q      <= '0;
                        norm_valid <= 1'b0;
`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
                        frame_err  <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
                    if (in_hs) begin
                        max_q <= cur_max;
`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
                        if (s_axis_tlast != (wr_cnt == LAST)) frame_err <= 1'b1;
`endif
                        if (frame_end) begin
                            wr_cnt           <= '0;
                            norm_valid       <= 1'b1;
                            norm_denominator <= (cur_max == '0) ? PIXEL_BIT_WIDTH'(1) : cur_max;
`ifdef NORM_FRAME_WRITER_TLAST_CHECK_EN
                            last_idx         <= wr_cnt;
`endif
                        end else begin
                            wr_cnt <= wr_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!m_valid) begin
                        m_data  <= mem[rd_cnt[AW-1:0]];
                        m_valid <= 1'b1;
                    end else if (m_axis_tready) begin
                        if (out_last) begin
                            m_valid <= 1'b0;
                            rd_cnt  <= '0;
                        end else begin
                            rd_cnt <= rd_next;
                            m_data <= mem[rd_next[AW-1:0]];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
